// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: instruction-fetch sequencer for the 1-bit computer's program ROM.
// Holds the program counter, drives the synchronous ROM (1-cycle read latency) and
// presents each instruction to the core over a valid/ready handshake.
// Optional build macro ROM_FETCH_CNT_EN adds a 16-bit saturating count of accepted
// instructions on fetch_cnt_o; without it fetch_cnt_o is tied to zero.
module rom_fetch_ctrl #(
    parameter int unsigned          ADR_W     = 8,
    parameter int unsigned          DAT_W     = 32,
    parameter logic [ADR_W-1:0]     RESET_ADR = '0,
    parameter logic [ADR_W-1:0]     LAST_ADR  = '1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    run_i,
    output logic [ADR_W-1:0]        rom_adr_o,
    input  logic [DAT_W-1:0]        rom_dat_i,
    output logic [DAT_W-1:0]        ins_o,
    output logic                    ins_vld_o,
    input  logic                    ins_rdy_i,
    input  logic                    jmp_i,
    input  logic [ADR_W-1:0]        jmp_adr_i,
    output logic [ADR_W-1:0]        pc_o,
    output logic [15:0]             fetch_cnt_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFetch = 2'b01,
        StValid = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [ADR_W-1:0]   pc_q, pc_d;
    logic [ADR_W-1:0]   pc_seq;
    logic [ADR_W-1:0]   pc_next;
    logic               hs;

    // Sequential successor: wrap at LAST_ADR, otherwise natural modulo-2^ADR_W increment
    // (covers jump targets above LAST_ADR, which count up until they roll over).
    always_comb begin
        if (pc_q == LAST_ADR) begin
            pc_seq = RESET_ADR;
        end else begin
            pc_seq = pc_q + ADR_W'(1);
        end
    end

    // A jump only matters in the handshake cycle; elsewhere pc_next is simply unused.
    always_comb begin
        pc_next = jmp_i ? jmp_adr_i : pc_seq;
    end

    // Handshake is only possible while an instruction is presented.
    always_comb begin
        hs = (state_q == StValid) && ins_rdy_i;
    end

    // Next-state and output decode for the fetch FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ins_vld_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // ROM samples rom_adr_o at the closing edge; run_i cannot abort.
                state_d = StValid;
            end
            StValid: begin
                ins_vld_o = 1'b1;
                if (hs) begin
                    pc_d    = pc_next;
                    state_d = run_i ? StFetch : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and program-counter registers; reset wins over any handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pc_q    <= RESET_ADR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // pc is held through VALID, so the ROM output stays stable while presented.
    always_comb begin
        rom_adr_o = pc_q;
        pc_o      = pc_q;
        ins_o     = ins_vld_o ? rom_dat_i : '0;
    end

`ifdef ROM_FETCH_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of accepted instructions.
    always_comb begin
        cnt_d = cnt_q;
        if (hs && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_cnt_o = cnt_q;
`else
    assign fetch_cnt_o = 16'h0000;
`endif

`ifndef SYNTHESIS
    // Presented instruction is never retracted and pc never moves without a handshake.
    a_vld_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (ins_vld_o && !ins_rdy_i) |=> (ins_vld_o && $stable(pc_q)));

    // Every VALID is preceded by exactly one FETCH cycle.
    a_fetch_to_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StFetch) |=> (state_q == StValid));

    // Only the three legal encodings are ever reached.
    a_state_legal: assert property (@(posedge clk_i)
        (state_q == StIdle) || (state_q == StFetch) || (state_q == StValid));
`endif

endmodule
